aes_spi_frontend: RTL and testbench
===================================

# aes_spi_frontend

SPI-side framing stage wrapped around the AES core. It deserialises a key and a 128-bit message from the host, then holds the core's `ce` high until a complete frame has been received and releases it to start the run. When the core reports `done`, it captures `translated` and serialises the result back to the host. All SPI pins are oversampled in the single system clock domain; no logic is clocked by `sck`.

## Interface
- `K`, default 128: key length; legal values 128, 192, 256.
- `FRAME`, default K+128: bits per input frame (derived; not overridden).
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `sck` in 1: SPI clock from host, idle low.
- `sdi` in 1: SPI data in, MSB first.
- `load` in 1: host frame strobe; high while input frame is shifted.
- `dir` in 1: 0 encrypt, 1 decrypt; registered when `load` falls.
- `sdo` out 1: SPI data out, MSB first.
- `ready` out 1: result available for readout.
- `frame_err` out 1: sticky; last frame had the wrong bit count.
- `core_ce` out 1: drives core `ce`.
- `core_key` out K: to core `key`.
- `core_msg` out 128: to core `message`.
- `core_dir` out 1: to core `dir`.
- `core_done` in 1: core `done2`.
- `core_out` in 128: core `translated`.

## Operation
- The input shift register holds FRAME bits. On each detected `sck` rise while `load` is high, it does `{sr[FRAME-2:0], sdi}`. Key bits come first, so `core_key = sr[FRAME-1:128]` and `core_msg = sr[127:0]`.
- The bit counter is $clog2(FRAME+1) wide, clears when `load` rises, and saturates at FRAME+1. An over-length frame keeps the last FRAME bits but is flagged as an error.
- FSM states: IDLE, SHIFT_IN, RUN, SHIFT_OUT.
  - IDLE → SHIFT_IN on `load` rise.
  - SHIFT_IN → RUN on `load` fall if count == FRAME. In that case `frame_err` clears and `dir` is latched into `core_dir`.
  - SHIFT_IN → IDLE on `load` fall if count != FRAME. In that case `frame_err` is set.
  - RUN → SHIFT_OUT on the first cycle `core_done` is sampled high. The output register loads `core_out` and `ready` goes to 1.
  - SHIFT_OUT: on each `sck` fall, the output register shifts left with zero fill. `sdo` = output register MSB.
  - SHIFT_OUT → IDLE after 128 falls. `ready` goes to 0 on the 128th fall.
  - From any state, a `load` rise goes to SHIFT_IN. This aborts a RUN or SHIFT_OUT, drops `ready`, and zeroes the output register.
- `core_ce = (state != RUN)`. The core is held in its load/reset condition except during RUN, so aborts restart it cleanly.
- `core_done` is ignored outside RUN.
- A `load` rise and an `sck` edge detected in the same cycle: the `load` rise wins, and that `sck` edge is not counted.
- Reset values: state IDLE; both shift registers 0; `sdo` 0; `ready` 0; `frame_err` 0; `core_ce` 1; `core_dir` 0.

## Timing
- Edge detection compares the current and previous registered copies of `sck`/`load`. Detection latency is L = 1 cycle without synchronisers and L = 3 with them.
- The host must keep `sck` high and low for at least L+1 `clk` cycles each.
- `core_ce` falls 1 cycle after the `load` fall is detected.
- `ready` rises, and `sdo` presents result bit 127, 1 cycle after `core_done` is sampled high.
- `sdo` updates 1 cycle after each detected `sck` fall. The host samples on the `sck` rise.
- Total latency from `load` fall to `ready` = L + 1 + core run time + 1.

## Configuration
- `AES_SPI_SYNC_EN` defined: `sck`, `sdi`, `load` and `dir` each pass through two-flop synchronisers before edge detection (L=3). Required whenever the host is asynchronous to `clk`.
- `AES_SPI_SYNC_EN` undefined: the pins are registered once (L=1). Only valid for synchronous benches.

## Structure
- Package `aes_pkg`:
  - `spi_state_t` enum (IDLE, SHIFT_IN, RUN, SHIFT_OUT).
  - `AES_BLOCK_BITS = 128`.
  - A function returning FRAME and the counter width from K.
- Sub-module `spi_edge_detect`, instantiated once per pin. It provides the optional synchroniser plus `rise`/`fall`/`level` outputs, and has the same `clk`/`reset` ports.

## Test plan
- Encrypt: FIPS-197 key 000102030405060708090a0b0c0d0e0f, message 00112233445566778899aabbccddeeff, `dir` 0 → `ready`=1; 128 `sck` pulses read out 69c4e0d86a7b0430d8cdb78070b4c55a; `frame_err`=0.
- Decrypt: same key, message 69c4e0d86a7b0430d8cdb78070b4c55a, `dir` 1 → readout 00112233445566778899aabbccddeeff.
- Short frame: 255 bits, then `load` low → `frame_err`=1; `core_ce` stays 1; `ready` stays 0; state IDLE.
- Long frame: 257 bits (one extra leading 1, then the FIPS frame) → `frame_err`=1; no run starts.
- Abort: raise `load` 5 cycles into RUN, then send the FIPS encrypt frame → `core_ce` returns to 1 immediately; single correct result 69c4e0d8...c55a.
- Reset mid-SHIFT_OUT after 40 bits: drive `reset` low → `ready`=0, `sdo`=0, `core_ce`=1 asynchronously; the next frame completes normally.

Source files
------------

// File: rtl/aes_pkg.sv
// ============================================================================
// aes_pkg: shared types and frame sizing for the AES SPI front end.
// Revision: 1.0
// ============================================================================
`default_nettype none

package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT_IN  = 2'd1,
    RUN       = 2'd2,
    SHIFT_OUT = 2'd3
  } spi_state_t;

  typedef struct packed {
    logic [31:0] frame;
    logic [31:0] cnt_w;
  } frame_cfg_t;

  // Frame length and a bit-counter width that can also hold FRAME+1.
  function automatic frame_cfg_t frame_cfg(input int k);
    frame_cfg_t c;
    c.frame = 32'(k + AES_BLOCK_BITS);
    c.cnt_w = 32'($clog2(k + AES_BLOCK_BITS + 1));
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_edge_detect.sv
// ============================================================================
// spi_edge_detect: registers one SPI pin (optionally through a two-flop
// synchroniser when AES_SPI_SYNC_EN is defined) and reports rise/fall/level.
// Revision: 1.0
// ============================================================================
`default_nettype none

module spi_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic rise,
  output logic fall,
  output logic level
);

  logic w_pin_s;
  logic r_cur;
  logic r_prev;

`ifdef AES_SPI_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], pin};
    end
  end

  assign w_pin_s = r_sync[1];
`else
  assign w_pin_s = pin;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= w_pin_s;
      r_prev <= r_cur;
    end
  end

  assign rise  = r_cur & ~r_prev;
  assign fall  = ~r_cur & r_prev;
  assign level = r_cur;

endmodule

`default_nettype wire

// File: rtl/aes_spi_frontend.sv
// ============================================================================
// aes_spi_frontend: SPI framing around the AES core - deserialises key and
// message, runs the core, serialises the result. Option: AES_SPI_SYNC_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module aes_spi_frontend
  import aes_pkg::*;
#(
  parameter int K = 128
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sck,
  input  logic                      sdi,
  input  logic                      load,
  input  logic                      dir,
  output logic                      sdo,
  output logic                      ready,
  output logic                      frame_err,
  output logic                      core_ce,
  output logic [K-1:0]              core_key,
  output logic [AES_BLOCK_BITS-1:0] core_msg,
  output logic                      core_dir,
  input  logic                      core_done,
  input  logic [AES_BLOCK_BITS-1:0] core_out
);

  localparam frame_cfg_t CFG = frame_cfg(K);
  localparam int FRAME = int'(CFG.frame);
  localparam int CW    = int'(CFG.cnt_w);
  localparam int OW    = $clog2(AES_BLOCK_BITS);

  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME + 1);
  localparam logic [OW-1:0] OUT_LAST = OW'(AES_BLOCK_BITS - 1);

  logic w_sck_rise, w_sck_fall, w_sck_level;
  logic w_sdi_rise, w_sdi_fall, w_sdi_level;
  logic w_load_rise, w_load_fall, w_load_level;
  logic w_dir_rise, w_dir_fall, w_dir_level;

  spi_edge_detect u_sck  (.clk(clk), .reset(reset), .pin(sck),
                          .rise(w_sck_rise), .fall(w_sck_fall), .level(w_sck_level));
  spi_edge_detect u_sdi  (.clk(clk), .reset(reset), .pin(sdi),
                          .rise(w_sdi_rise), .fall(w_sdi_fall), .level(w_sdi_level));
  spi_edge_detect u_load (.clk(clk), .reset(reset), .pin(load),
                          .rise(w_load_rise), .fall(w_load_fall), .level(w_load_level));
  spi_edge_detect u_dir  (.clk(clk), .reset(reset), .pin(dir),
                          .rise(w_dir_rise), .fall(w_dir_fall), .level(w_dir_level));

  logic w_unused_edges;
  assign w_unused_edges = ^{w_sck_level, w_sdi_rise, w_sdi_fall, w_dir_rise, w_dir_fall};

  spi_state_t               r_state, w_state_nxt;
  logic [FRAME-1:0]          r_sr_in;
  logic [CW-1:0]             r_cnt;
  logic [AES_BLOCK_BITS-1:0] r_sr_out;
  logic [OW-1:0]             r_out_cnt;
  logic                      r_ready;
  logic                      r_frame_err;
  logic                      r_core_dir;

  logic w_shift_in, w_shift_out, w_frame_ok, w_frame_bad, w_capture;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A load rise overrides everything, including an sck edge in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_in  = 1'b0;
    w_shift_out = 1'b0;
    w_frame_ok  = 1'b0;
    w_frame_bad = 1'b0;
    w_capture   = 1'b0;
    if (w_load_rise) begin
      w_state_nxt = SHIFT_IN;
    end else begin
      case (r_state)
        IDLE: begin
          w_state_nxt = IDLE;
        end
        SHIFT_IN: begin
          if (w_load_fall) begin
            if (r_cnt == CNT_FULL) begin
              w_state_nxt = RUN;
              w_frame_ok  = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_frame_bad = 1'b1;
            end
          end else if (w_sck_rise && w_load_level) begin
            w_shift_in = 1'b1;
          end
        end
        RUN: begin
          if (core_done) begin
            w_state_nxt = SHIFT_OUT;
            w_capture   = 1'b1;
          end
        end
        SHIFT_OUT: begin
          if (w_sck_fall) begin
            w_shift_out = 1'b1;
            if (r_out_cnt == OUT_LAST) begin
              w_state_nxt = IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr_in     <= '0;
      r_cnt       <= '0;
      r_sr_out    <= '0;
      r_out_cnt   <= '0;
      r_ready     <= 1'b0;
      r_frame_err <= 1'b0;
      r_core_dir  <= 1'b0;
    end else begin
      if (w_load_rise) begin
        r_cnt    <= '0;
        r_sr_out <= '0;
        r_ready  <= 1'b0;
      end
      if (w_shift_in) begin
        r_sr_in <= {r_sr_in[FRAME-2:0], w_sdi_level};
        if (r_cnt != CNT_SAT) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_frame_ok) begin
        r_frame_err <= 1'b0;
        r_core_dir  <= w_dir_level;
      end
      if (w_frame_bad) begin
        r_frame_err <= 1'b1;
      end
      if (w_capture) begin
        r_sr_out  <= core_out;
        r_ready   <= 1'b1;
        r_out_cnt <= '0;
      end
      if (w_shift_out) begin
        r_sr_out  <= {r_sr_out[AES_BLOCK_BITS-2:0], 1'b0};
        r_out_cnt <= r_out_cnt + 1'b1;
        if (r_out_cnt == OUT_LAST) begin
          r_ready <= 1'b0;
        end
      end
    end
  end

  // The core is held in its load condition everywhere except RUN.
  assign core_ce   = (r_state != RUN);
  assign core_key  = r_sr_in[FRAME-1:AES_BLOCK_BITS];
  assign core_msg  = r_sr_in[AES_BLOCK_BITS-1:0];
  assign core_dir  = r_core_dir;
  assign sdo       = r_sr_out[AES_BLOCK_BITS-1];
  assign ready     = r_ready;
  assign frame_err = r_frame_err;

endmodule

`default_nettype wire

// File: tb/tb_aes_spi_frontend.sv
// Bench for aes_spi_frontend: acts as SPI host and as a stand-in AES core whose
// transform is known to the reference model (FIPS-197 vectors map exactly).
`timescale 1ns/1ps
`default_nettype none

module tb_aes_spi_frontend;

`ifdef AES_SPI_SYNC_EN
  localparam int L = 3;
`else
  localparam int L = 1;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic sck = 1'b0, sdi = 1'b0, load = 1'b0, dir = 1'b0;
  logic sdo, ready, frame_err, core_ce, core_dir;
  logic core_done = 1'b0;
  logic [127:0] core_key, core_msg;
  logic [127:0] core_out = '0;

  int checks = 0;
  int failures = 0;
  int run_len = 8;
  int core_cnt = 0;
  int ready_rises = 0;
  logic prev_ready = 1'b0;
  logic [127:0] exp_key = '0, exp_msg = '0;
  logic exp_dir = 1'b0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  aes_spi_frontend #(.K(128)) dut (
    .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .load(load), .dir(dir),
    .sdo(sdo), .ready(ready), .frame_err(frame_err), .core_ce(core_ce),
    .core_key(core_key), .core_msg(core_msg), .core_dir(core_dir),
    .core_done(core_done), .core_out(core_out)
  );

  // Reference transform of the stand-in core.
  function automatic logic [127:0] ref_core(input logic [127:0] k, input logic [127:0] m,
                                            input logic d);
    if (k == FIPS_KEY && m == FIPS_PT && !d) return FIPS_CT;
    if (k == FIPS_KEY && m == FIPS_CT && d)  return FIPS_PT;
    if (d) return ~(m ^ {k[63:0], k[127:64]});
    return {m[95:0], m[127:96]} ^ k;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in core: restarts whenever ce is high, finishes run_len cycles after ce drops.
  always @(negedge clk) begin
    if (core_ce !== 1'b0) begin
      core_cnt  = 0;
      core_done = 1'b0;
      core_out  = '0;
    end else begin
      core_cnt++;
      if (core_cnt == run_len) begin
        core_done = 1'b1;
        core_out  = ref_core(core_key, core_msg, core_dir);
      end
    end
  end

  // Per-cycle compare: while the core runs it must see exactly the last good frame.
  always @(negedge clk) begin
    if (mon_en && reset === 1'b1) begin
      if (core_ce === 1'b0) begin
        check("run_key", core_key, exp_key);
        check("run_msg", core_msg, exp_msg);
        check("run_dir", {127'b0, core_dir}, {127'b0, exp_dir});
      end
      if (ready === 1'b1) check("ready_implies_ce", {127'b0, core_ce}, 128'd1);
    end
    if (ready === 1'b1 && prev_ready !== 1'b1) ready_rises++;
    prev_ready = ready;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic int hold();
    return L + 1 + int'($urandom_range(0, 2));
  endfunction

  task automatic send_frame(input logic [259:0] bits, input int n, input logic d);
    load = 1'b1;
    dir  = d;
    wait_cyc(L + 3);
    for (int i = n - 1; i >= 0; i--) begin
      sdi = bits[i];
      wait_cyc(hold());
      sck = 1'b1;
      wait_cyc(hold());
      sck = 1'b0;
    end
    wait_cyc(hold());
    if (n == 256) begin
      exp_key = bits[255:128];
      exp_msg = bits[127:0];
      exp_dir = d;
    end
    load = 1'b0;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (ready === 1'b1) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check("ready_timeout", {127'b0, ready}, 128'd1);
  endtask

  task automatic read_out(input int nbits, output logic [127:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      got = {got[126:0], sdo};
      sck = 1'b1;
      wait_cyc(hold());
      sck = 1'b0;
      wait_cyc(hold());
    end
  endtask

  task automatic txn(input logic [127:0] k, input logic [127:0] m, input logic d,
                     input string name, output logic [127:0] got);
    bit ok;
    got = 'x;
    send_frame({4'b0, k, m}, 256, d);
    wait_ready(ok);
    if (ok) begin
      read_out(128, got);
      check(name, got, ref_core(k, m, d));
      wait_cyc(L + 2);
      check({name, "_ready_low"}, {127'b0, ready}, 128'd0);
      check({name, "_ce_idle"}, {127'b0, core_ce}, 128'd1);
      check({name, "_frame_err"}, {127'b0, frame_err}, 128'd0);
    end
  endtask

  task automatic bad_frame(input logic [259:0] bits, input int n, input string name);
    bit ce_ok, rdy_ok;
    send_frame(bits, n, 1'b0);
    wait_cyc(L + 3);
    check({name, "_frame_err"}, {127'b0, frame_err}, 128'd1);
    ce_ok = 1'b1;
    rdy_ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (core_ce !== 1'b1) ce_ok = 1'b0;
      if (ready !== 1'b0) rdy_ok = 1'b0;
      @(negedge clk);
    end
    check({name, "_no_run"}, {127'b0, ce_ok}, 128'd1);
    check({name, "_no_ready"}, {127'b0, rdy_ok}, 128'd1);
  endtask

  initial begin
    logic [127:0] got, k, m, ct;
    logic [259:0] bits;
    bit ok;
    int rc0, kind, n;

    wait_cyc(3);
    check("rst_sdo", {127'b0, sdo}, 128'd0);
    check("rst_ready", {127'b0, ready}, 128'd0);
    check("rst_frame_err", {127'b0, frame_err}, 128'd0);
    check("rst_core_ce", {127'b0, core_ce}, 128'd1);
    check("rst_core_dir", {127'b0, core_dir}, 128'd0);
    check("rst_core_key", core_key, 128'd0);
    check("rst_core_msg", core_msg, 128'd0);
    reset = 1'b1;
    wait_cyc(3);
    mon_en = 1'b1;

    run_len = 10;
    txn(FIPS_KEY, FIPS_PT, 1'b0, "fips_enc", got);
    check("fips_enc_literal", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    run_len = 6;
    txn(FIPS_KEY, FIPS_CT, 1'b1, "fips_dec", got);
    check("fips_dec_literal", got, 128'h00112233445566778899aabbccddeeff);

    bits = {4'b0, FIPS_KEY, FIPS_PT} >> 1;
    bad_frame(bits, 255, "short");
    bits = {3'b0, 1'b1, FIPS_KEY, FIPS_PT};
    bad_frame(bits, 257, "long");
    check("long_keeps_key", core_key, FIPS_KEY);
    check("long_keeps_msg", core_msg, FIPS_PT);

    // Abort a run, then resend the encrypt frame.
    run_len = 60;
    rc0 = ready_rises;
    send_frame({4'b0, FIPS_KEY, FIPS_PT}, 256, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (core_ce === 1'b0) ok = 1'b1;
      else @(negedge clk);
    end
    check("abort_run_started", {127'b0, ok}, 128'd1);
    wait_cyc(5);
    load = 1'b1;
    wait_cyc(L + 2);
    check("abort_ce_high", {127'b0, core_ce}, 128'd1);
    check("abort_ready_low", {127'b0, ready}, 128'd0);
    run_len = 12;
    txn(FIPS_KEY, FIPS_PT, 1'b0, "abort_enc", got);
    check("abort_enc_literal", got, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check("abort_single_result", 128'(ready_rises - rc0), 128'd1);

    // Reset in the middle of readout.
    run_len = 7;
    send_frame({4'b0, FIPS_KEY, FIPS_PT}, 256, 1'b0);
    wait_ready(ok);
    if (ok) begin
      read_out(40, got);
      ct = FIPS_CT;
      check("partial_40", {88'b0, got[39:0]}, {88'b0, ct[127:88]});
      #2 reset = 1'b0;
      #1;
      check("async_rst_ready", {127'b0, ready}, 128'd0);
      check("async_rst_sdo", {127'b0, sdo}, 128'd0);
      check("async_rst_ce", {127'b0, core_ce}, 128'd1);
      @(negedge clk);
      wait_cyc(2);
      reset = 1'b1;
      wait_cyc(3);
    end
    k = {$urandom, $urandom, $urandom, $urandom};
    m = {$urandom, $urandom, $urandom, $urandom};
    txn(k, m, 1'b1, "after_reset", got);

    // Randomised mix of good frames, wrong-length frames and aborts.
    for (int it = 0; it < 5; it++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      m = {$urandom, $urandom, $urandom, $urandom};
      run_len = int'($urandom_range(3, 25));
      kind = int'($urandom_range(0, 4));
      if (kind == 0) begin
        n = ($urandom_range(0, 1) == 0) ? 256 - int'($urandom_range(1, 2))
                                        : 256 + int'($urandom_range(1, 3));
        bits = {4'($urandom), k, m};
        bad_frame(bits, n, "rand_badlen");
      end else if (kind == 1) begin
        run_len = 60;
        send_frame({4'b0, m, k}, 256, 1'b0);
        wait_cyc(L + 8);
        load = 1'b1;
        wait_cyc(L + 2);
        check("rand_abort_ce", {127'b0, core_ce}, 128'd1);
        run_len = int'($urandom_range(3, 25));
        txn(k, m, 1'($urandom), "rand_abort_txn", got);
      end else begin
        txn(k, m, 1'($urandom), "rand_txn", got);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
